// File: rtl/run_length_detector.sv
// Start/detect controller: after s, counts cycles with x=1 and raises g when the count reaches TARGET.
// Optional cycle timeout in COUNT is enabled by defining RLD_TIMEOUT_EN.
module run_length_detector #(
    parameter int WIDTH       = 4,
    parameter int TARGET      = 15,
    parameter bit CONSEC      = 1'b1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             x,
    input  logic             clr,
    output logic             g,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
`ifdef RLD_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10,
        TOUT  = 2'b11
    } state_t;

    if (TARGET < 1 || TARGET > (2**WIDTH) - 1) begin : g_bad_target
        $error("run_length_detector: TARGET must lie in 1..2**WIDTH-1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("run_length_detector: TIMEOUT_CYC must be at least 1");
    end

    // One extra bit on the sum keeps the compare exact when TARGET is the all-ones value.
    localparam logic [WIDTH:0] TGT = (WIDTH+1)'(TARGET);

    state_t         state_q;
    logic [WIDTH:0] cnt_inc;
    logic           hit;

    assign cnt_inc = {1'b0, cnt} + (WIDTH+1)'(1);
    assign hit     = x && (cnt_inc == TGT);
    assign state   = state_q;

`ifdef RLD_TIMEOUT_EN
    localparam int          TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW:0] TLIM = (TW+1)'(TIMEOUT_CYC);

    logic [TW-1:0] tcnt;
    logic [TW:0]   tcnt_inc;
    logic          expire;

    assign tcnt_inc = {1'b0, tcnt} + (TW+1)'(1);
    assign expire   = (tcnt_inc == TLIM);
`endif

    // NOTE: all state below is updated with non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= IDLE;
            cnt     <= '0;
            g       <= 1'b0;
            busy    <= 1'b0;
`ifdef RLD_TIMEOUT_EN
            timeout <= 1'b0;
            tcnt    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= COUNT;
                        busy    <= 1'b1;
                        cnt     <= '0;
`ifdef RLD_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end
                end

                COUNT: begin
                    if (x) begin
                        cnt <= cnt_inc[WIDTH-1:0];
                    end else if (CONSEC) begin
                        cnt <= '0;
                    end
`ifdef RLD_TIMEOUT_EN
                    tcnt <= tcnt_inc[TW-1:0];
`endif
                    // Reaching TARGET takes precedence over a coincident timeout.
                    if (hit) begin
                        state_q <= DONE;
                        g       <= 1'b1;
                        busy    <= 1'b0;
                    end
`ifdef RLD_TIMEOUT_EN
                    else if (expire) begin
                        state_q <= TOUT;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                    end
`endif
                end

                DONE: begin
                    if (!s) begin
                        state_q <= IDLE;
                        g       <= 1'b0;
                        cnt     <= '0;
                    end
                end

`ifdef RLD_TIMEOUT_EN
                TOUT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        timeout <= 1'b0;
                        cnt     <= '0;
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                    cnt     <= '0;
                    g       <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector: a run-length instance (CONSEC=1) and a
// cumulative instance (CONSEC=0) share stimulus and are checked against hand-computed values.
module tb_run_length_detector;

    logic       clk;
    logic       rst;
    logic       s;
    logic       x;
    logic       clr;
    logic       g_a, busy_a, g_b, busy_b;
    logic [3:0] cnt_a, cnt_b;
    logic [1:0] state_a, state_b;

    int checks;
    int errors;

    run_length_detector #(.WIDTH(4), .TARGET(15), .CONSEC(1'b1), .TIMEOUT_CYC(64)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .x    (x),
        .clr  (clr),
        .g    (g_a),
        .busy (busy_a),
        .cnt  (cnt_a),
        .state(state_a)
    );

    run_length_detector #(.WIDTH(4), .TARGET(15), .CONSEC(1'b0), .TIMEOUT_CYC(64)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .x    (x),
        .clr  (clr),
        .g    (g_b),
        .busy (busy_b),
        .cnt  (cnt_b),
        .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       s;
        logic       x;
        logic       clr;
        logic       g;
        logic       busy;
        logic [3:0] cnt;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input int g, input int busy, input int cnt, input int st);
        check({tag, " a.g"}, int'(g_a), g);
        check({tag, " a.busy"}, int'(busy_a), busy);
        check({tag, " a.cnt"}, int'(cnt_a), cnt);
        check({tag, " a.state"}, int'(state_a), st);
    endtask

    task automatic check_b(input string tag, input int g, input int busy, input int cnt, input int st);
        check({tag, " b.g"}, int'(g_b), g);
        check({tag, " b.busy"}, int'(busy_b), busy);
        check({tag, " b.cnt"}, int'(cnt_b), cnt);
        check({tag, " b.state"}, int'(state_b), st);
    endtask

    task automatic drive(input logic r, input logic sv, input logic xv, input logic cv);
        rst = r;
        s   = sv;
        x   = xv;
        clr = cv;
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic sv, input logic xv, input logic cv,
                                input logic eg, input logic eb, input int ec, input int es);
        vec_t v;
        v.rst  = r;
        v.s    = sv;
        v.x    = xv;
        v.clr  = cv;
        v.g    = eg;
        v.busy = eb;
        v.cnt  = 4'(ec);
        v.st   = 2'(es);
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);

        // Reset held two edges with s and x high, then a full run to TARGET and release.
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1));
        for (int c = 1; c <= 14; c++) tbl.push_back(mk(0, 1, 1, 0, 0, 1, c, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 15, 2));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 15, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 15, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].s, tbl[i].x, tbl[i].clr);
            step();
            check_a($sformatf("tbl%0d", i), tbl[i].g, tbl[i].busy, tbl[i].cnt, tbl[i].st);
            check_b($sformatf("tbl%0d", i), tbl[i].g, tbl[i].busy, tbl[i].cnt, tbl[i].st);
        end

        // Gap in the x stream: run-length instance restarts, cumulative instance holds 7.
        drive(0, 1, 1, 0);
        step();
        check_a("gap.enter", 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) step();
        check_a("gap.pre", 0, 1, 7, 1);
        check_b("gap.pre", 0, 1, 7, 1);
        drive(0, 1, 0, 0);
        step();
        check_a("gap.zero", 0, 1, 0, 1);
        check_b("gap.zero", 0, 1, 7, 1);
        drive(0, 1, 1, 0);
        for (int i = 0; i < 15; i++) begin
            step();
            check_a($sformatf("gap.a%0d", i), (i == 14) ? 1 : 0, (i == 14) ? 0 : 1,
                    i + 1, (i == 14) ? 2 : 1);
            check_b($sformatf("gap.b%0d", i), (i >= 7) ? 1 : 0, (i >= 7) ? 0 : 1,
                    (8 + i > 15) ? 15 : 8 + i, (i >= 7) ? 2 : 1);
        end

        // Re-arm from DONE: s low one edge, then high restarts at zero.
        drive(0, 0, 1, 0);
        step();
        check_a("rearm.idle", 0, 0, 0, 0);
        drive(0, 1, 1, 0);
        step();
        check_a("rearm.count", 0, 1, 0, 1);

        // clr at cnt=9 with s still high, then COUNT re-entered next edge.
        for (int i = 0; i < 9; i++) step();
        check_a("clr.pre", 0, 1, 9, 1);
        drive(0, 1, 1, 1);
        step();
        check_a("clr.abort", 0, 0, 0, 0);
        drive(0, 1, 1, 0);
        step();
        check_a("clr.reenter", 0, 1, 0, 1);

        // clr coincident with the final qualifying x: g must stay low.
        for (int i = 0; i < 14; i++) step();
        check_a("clrfin.pre", 0, 1, 14, 1);
        drive(0, 1, 1, 1);
        step();
        check_a("clrfin.abort", 0, 0, 0, 0);

        // Dropping s inside COUNT does not abort; rst mid-count discards the count.
        drive(0, 1, 1, 0);
        step();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step();
        check_a("sdrop.hold", 0, 1, 3, 1);
        drive(1, 1, 1, 1);
        step();
        check_a("rst.mid", 0, 0, 0, 0);
        check_b("rst.mid", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
